pipeline_hazard_ctrl: RTL and testbench

Central hazard controller for the five-stage RISC-V pipeline (Instruction_Fetch → ID_and_RF → exec → Memory → Write_Back). It keeps a shadow record of destination registers and writeback/load flags for the instructions in EX, MEM and WB. From that record it drives the PC/IF-ID write enables, bubble and flush controls, and the ALU forwarding selects. It also counts stall and flush cycles for performance measurement.

---
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: ID-stage decode and branch resolution in,
// pipeline enables, bubble/flush controls, forwarding selects and counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   id_valid;
  logic [4:0]             id_rs1;
  logic [4:0]             id_rs2;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic [4:0]             id_rd;
  logic                   id_regWrite;
  logic                   id_Mem_Read;
  logic                   PC_SRC;
  logic                   pc_write;
  logic                   ifid_write;
  logic                   ifid_flush;
  logic                   idex_flush;
  logic                   exmem_flush;
  logic [1:0]             Forward_A;
  logic [1:0]             Forward_B;
  logic [1:0]             ctrl_state;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic [STALL_CNT_W-1:0] flush_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regWrite, id_Mem_Read, PC_SRC,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
           Forward_A, Forward_B, ctrl_state, stall_cycles, flush_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regWrite, id_Mem_Read, PC_SRC,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
           Forward_A, Forward_B, ctrl_state, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: stall/flush/forward decisions from a shadow of EX/MEM/WB.
// Define HAZARD_FORWARDING_EN for operand forwarding and single-bubble load-use stalls.
module pipeline_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);
  // state | meaning
  // RUN   | pipeline advanced normally last cycle
  // STALL | PC and IF/ID held, bubble inserted into EX
  // FLUSH | taken branch squashed IF/ID, ID/EX and EX/MEM
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } action_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       regWrite;
    logic       Mem_Read;
  } slot_t;

  slot_t                  ex_q, mem_q, wb_q, id_slot;
  action_e                state_q, action;
  logic [STALL_CNT_W-1:0] stall_q, flush_q;
  logic                   br, hazard;
  logic [1:0]             fwd_a, fwd_b;
  logic                   slot_unused;

  function automatic logic prod_hit(input logic valid, input logic reg_write,
                                    input logic [4:0] rd, input logic [4:0] rs,
                                    input logic uses);
    return valid & reg_write & (rd != 5'd0) & (rd == rs) & uses;
  endfunction

  assign id_slot = '{valid: hz.id_valid, rd: hz.id_rd, rs1: hz.id_rs1, rs2: hz.id_rs2,
                     uses_rs1: hz.id_uses_rs1, uses_rs2: hz.id_uses_rs2,
                     regWrite: hz.id_regWrite, Mem_Read: hz.id_Mem_Read};

  // A PC_SRC pulse coming from a squashed MEM slot must not redirect fetch.
  assign br = hz.PC_SRC & mem_q.valid;

`ifdef HAZARD_FORWARDING_EN
  assign hazard = ex_q.Mem_Read &
                  (prod_hit(ex_q.valid, ex_q.regWrite, ex_q.rd, hz.id_rs1, hz.id_uses_rs1) |
                   prod_hit(ex_q.valid, ex_q.regWrite, ex_q.rd, hz.id_rs2, hz.id_uses_rs2));

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_q.valid) begin
      if (prod_hit(mem_q.valid, mem_q.regWrite, mem_q.rd, ex_q.rs1, ex_q.uses_rs1))
        fwd_a = 2'b10;
      else if (prod_hit(wb_q.valid, wb_q.regWrite, wb_q.rd, ex_q.rs1, ex_q.uses_rs1))
        fwd_a = 2'b01;
      if (prod_hit(mem_q.valid, mem_q.regWrite, mem_q.rd, ex_q.rs2, ex_q.uses_rs2))
        fwd_b = 2'b10;
      else if (prod_hit(wb_q.valid, wb_q.regWrite, wb_q.rd, ex_q.rs2, ex_q.uses_rs2))
        fwd_b = 2'b01;
    end
  end

  assign slot_unused = ^{mem_q.rs1, mem_q.rs2, mem_q.uses_rs1, mem_q.uses_rs2, mem_q.Mem_Read,
                         wb_q.rs1, wb_q.rs2, wb_q.uses_rs1, wb_q.uses_rs2, wb_q.Mem_Read};
`else
  // Without bypass paths a consumer waits until its producer has left WB.
  assign hazard =
    prod_hit(ex_q.valid,  ex_q.regWrite,  ex_q.rd,  hz.id_rs1, hz.id_uses_rs1) |
    prod_hit(ex_q.valid,  ex_q.regWrite,  ex_q.rd,  hz.id_rs2, hz.id_uses_rs2) |
    prod_hit(mem_q.valid, mem_q.regWrite, mem_q.rd, hz.id_rs1, hz.id_uses_rs1) |
    prod_hit(mem_q.valid, mem_q.regWrite, mem_q.rd, hz.id_rs2, hz.id_uses_rs2) |
    prod_hit(wb_q.valid,  wb_q.regWrite,  wb_q.rd,  hz.id_rs1, hz.id_uses_rs1) |
    prod_hit(wb_q.valid,  wb_q.regWrite,  wb_q.rd,  hz.id_rs2, hz.id_uses_rs2);

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;

  assign slot_unused = ^{ex_q.rs1, ex_q.rs2, ex_q.uses_rs1, ex_q.uses_rs2, ex_q.Mem_Read,
                         mem_q.rs1, mem_q.rs2, mem_q.uses_rs1, mem_q.uses_rs2, mem_q.Mem_Read,
                         wb_q.rs1, wb_q.rs2, wb_q.uses_rs1, wb_q.uses_rs2, wb_q.Mem_Read};
`endif

  always_comb begin
    action         = RUN;
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.exmem_flush = 1'b0;
    if (br) begin
      action         = FLUSH;
      hz.ifid_flush  = 1'b1;
      hz.idex_flush  = 1'b1;
      hz.exmem_flush = 1'b1;
    end else if (hz.id_valid && hazard) begin
      action        = STALL;
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= action;
      wb_q    <= mem_q;
      mem_q   <= (action == FLUSH) ? '0 : ex_q;
      ex_q    <= (action == RUN) ? id_slot : '0;
      if (action == STALL && !(&stall_q))
        stall_q <= stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      if (action == FLUSH && !(&flush_q))
        flush_q <= flush_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign hz.Forward_A    = fwd_a;
  assign hz.Forward_B    = fwd_b;
  assign hz.ctrl_state   = state_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_cycles = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl; expectations follow
// the HAZARD_FORWARDING_EN setting of the build.
module tb_pipeline_hazard_ctrl;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
    logic [1:0] e_pw;
    logic [2:0] e_fl;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
    logic [1:0] e_cs;
  } vec_t;

  localparam logic [1:0] PW_RUN = 2'b11;
  localparam logic [1:0] PW_STL = 2'b00;
  localparam logic [2:0] FL_NO  = 3'b000;
  localparam logic [2:0] FL_STL = 3'b010;
  localparam logic [2:0] FL_ALL = 3'b111;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.STALL_CNT_W(16)) hz ();
  pipeline_hazard_ctrl_if #(.STALL_CNT_W(4))  hz4 ();

  pipeline_hazard_ctrl #(.STALL_CNT_W(16)) dut  (.clk(clk), .reset(reset), .hz(hz));
  pipeline_hazard_ctrl #(.STALL_CNT_W(4))  dut4 (.clk(clk), .reset(reset), .hz(hz4));

  assign hz4.id_valid    = hz.id_valid;
  assign hz4.id_rs1      = hz.id_rs1;
  assign hz4.id_rs2      = hz.id_rs2;
  assign hz4.id_uses_rs1 = hz.id_uses_rs1;
  assign hz4.id_uses_rs2 = hz.id_uses_rs2;
  assign hz4.id_rd       = hz.id_rd;
  assign hz4.id_regWrite = hz.id_regWrite;
  assign hz4.id_Mem_Read = hz.id_Mem_Read;
  assign hz4.PC_SRC      = hz.PC_SRC;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic br,
                              input logic [1:0] e_pw, input logic [2:0] e_fl,
                              input logic [1:0] e_fa, input logic [1:0] e_fb,
                              input logic [1:0] e_cs);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
    r.rw = rw; r.mr = mr; r.br = br;
    r.e_pw = e_pw; r.e_fl = e_fl; r.e_fa = e_fa; r.e_fb = e_fb; r.e_cs = e_cs;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    hz.id_valid    = x.v;
    hz.id_rs1      = x.rs1;
    hz.id_rs2      = x.rs2;
    hz.id_uses_rs1 = x.u1;
    hz.id_uses_rs2 = x.u2;
    hz.id_rd       = x.rd;
    hz.id_regWrite = x.rw;
    hz.id_Mem_Read = x.mr;
    hz.PC_SRC      = x.br;
  endtask

  // Called just after a rising edge: drive, check on the falling edge, step past the next edge.
  task automatic cyc(input vec_t x, input string tag);
    drive(x);
    @(negedge clk);
    chk({tag, " pc_write"},    32'(hz.pc_write),    32'(x.e_pw[1]));
    chk({tag, " ifid_write"},  32'(hz.ifid_write),  32'(x.e_pw[0]));
    chk({tag, " ifid_flush"},  32'(hz.ifid_flush),  32'(x.e_fl[2]));
    chk({tag, " idex_flush"},  32'(hz.idex_flush),  32'(x.e_fl[1]));
    chk({tag, " exmem_flush"}, 32'(hz.exmem_flush), 32'(x.e_fl[0]));
    chk({tag, " Forward_A"},   32'(hz.Forward_A),   32'(x.e_fa));
    chk({tag, " Forward_B"},   32'(hz.Forward_B),   32'(x.e_fb));
    chk({tag, " ctrl_state"},  32'(hz.ctrl_state),  32'(x.e_cs));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, PW_RUN, FL_NO, 2'b00, 2'b00, 2'b00);
    drive(idle);

`ifdef HAZARD_FORWARDING_EN
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // idle
    tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // add x5
    tbl.push_back(mk(1, 5, 5, 1, 1, 8, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // sub x8,x5,x5
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, PW_RUN, FL_NO,  2'b10, 2'b10, 2'b00)); // sub in EX
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // addi x0
    tbl.push_back(mk(1, 0, 0, 1, 1,10, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // add x10,x0,x0
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // x0 never fwd
    tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // ld x5
    tbl.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, PW_STL, FL_STL, 2'b00, 2'b00, 2'b00)); // add x6,x5,x7
    tbl.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b01)); // one bubble
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, PW_RUN, FL_NO,  2'b01, 2'b00, 2'b00)); // fwd from WB
    tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // add x5
    tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // add x5 again
    tbl.push_back(mk(1, 5, 5, 1, 1, 8, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // sub x8,x5,x5
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, PW_RUN, FL_NO,  2'b10, 2'b10, 2'b00)); // MEM over WB
`else
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // idle
    tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // add x5
    tbl.push_back(mk(1, 5, 5, 1, 1, 8, 1, 0, 0, PW_STL, FL_STL, 2'b00, 2'b00, 2'b00)); // dep on EX
    tbl.push_back(mk(1, 5, 5, 1, 1, 8, 1, 0, 0, PW_STL, FL_STL, 2'b00, 2'b00, 2'b01)); // dep on MEM
    tbl.push_back(mk(1, 5, 5, 1, 1, 8, 1, 0, 0, PW_STL, FL_STL, 2'b00, 2'b00, 2'b01)); // dep on WB
    tbl.push_back(mk(1, 5, 5, 1, 1, 8, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b01)); // released
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // addi x0
    tbl.push_back(mk(1, 0, 0, 1, 1,10, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // reads x0
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // idle
    tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // ld x5
    tbl.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, PW_STL, FL_STL, 2'b00, 2'b00, 2'b00)); // add x6,x5,x7
    tbl.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, PW_STL, FL_STL, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, PW_STL, FL_STL, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00)); // no fwd
`endif

    // Reset state
    #16;
    reset = 1'b1;
    drive(idle);
    @(negedge clk);
    chk("reset stall_cycles", 32'(hz.stall_cycles), 32'd0);
    chk("reset flush_cycles", 32'(hz.flush_cycles), 32'd0);
    @(posedge clk);
    #1;
    cyc(idle, "reset");

    // Vector table from a clean pipeline
    do_reset();
    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i], $sformatf("vec%0d", i));
    chk("table stall_cycles", 32'(hz.stall_cycles), FWD ? 32'd1 : 32'd6);
    chk("table flush_cycles", 32'(hz.flush_cycles), 32'd0);

    // Branch taken while a load-use hazard is also present
    do_reset();
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00), "br nop");
    cyc(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00), "br ld");
    cyc(mk(1, 5, 7, 1, 1, 6, 1, 0, 1, PW_RUN, FL_ALL, 2'b00, 2'b00, 2'b00), "br flush");
    chk("br flush_cycles", 32'(hz.flush_cycles), 32'd1);
    chk("br stall_cycles", 32'(hz.stall_cycles), 32'd0);
    cyc(mk(1, 5, 7, 1, 1, 6, 1, 0, 1, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b10), "br squashed");
    cyc(idle, "br after");
    chk("br flush_cycles held", 32'(hz.flush_cycles), 32'd1);

    // Reset asserted in the middle of a stall
    do_reset();
    cyc(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, PW_RUN, FL_NO,  2'b00, 2'b00, 2'b00), "mr ld");
    cyc(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, PW_STL, FL_STL, 2'b00, 2'b00, 2'b00), "mr stall");
    drive(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, PW_RUN, FL_NO, 2'b00, 2'b00, 2'b00));
    #1;
    chk("mr pre idex_flush", 32'(hz.idex_flush), FWD ? 32'd0 : 32'd1);
    reset = 1'b0;
    #1;
    chk("mr async pc_write",     32'(hz.pc_write),     32'd1);
    chk("mr async ifid_write",   32'(hz.ifid_write),   32'd1);
    chk("mr async idex_flush",   32'(hz.idex_flush),   32'd0);
    chk("mr async stall_cycles", 32'(hz.stall_cycles), 32'd0);
    chk("mr async ctrl_state",   32'(hz.ctrl_state),   32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, PW_RUN, FL_NO, 2'b00, 2'b00, 2'b00), "mr release");
    cyc(idle, "mr after");

    // Repeated self-dependent instruction to drive many stalls and saturate the narrow counter
    do_reset();
    drive(FWD ? mk(1, 5, 0, 1, 0, 5, 1, 1, 0, PW_RUN, FL_NO, 2'b00, 2'b00, 2'b00)
              : mk(1, 5, 5, 1, 1, 5, 1, 0, 0, PW_RUN, FL_NO, 2'b00, 2'b00, 2'b00));
    repeat (40) @(posedge clk);
    #1;
    drive(idle);
    @(negedge clk);
    chk("sat stall_cycles w16", 32'(hz.stall_cycles),  FWD ? 32'd20 : 32'd30);
    chk("sat stall_cycles w4",  32'(hz4.stall_cycles), 32'd15);
    chk("sat flush_cycles w4",  32'(hz4.flush_cycles), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
